uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The module SHALL have parameter CLK_FREQ_HZ, default 125000000, meaning the system clock frequency in Hz.
REQ-002 The module SHALL have parameter BAUD_RATE, default 115200, meaning the serial bit rate.
REQ-003 The module SHALL have localparam BAUD_DIV = CLK_FREQ_HZ / BAUD_RATE (integer division), meaning clocks per bit; elaboration SHALL fail if BAUD_DIV < 2.
REQ-004 The module SHALL have port clk, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1, meaning reset, asynchronous assert, active-low.
REQ-006 The module SHALL have port fifo_empty, input, 1, meaning the upstream TX FIFO holds no data.
REQ-007 The module SHALL have port fifo_rd_data, input, 8, meaning the show-ahead FIFO head byte, valid whenever fifo_empty=0.
REQ-008 The module SHALL have port fifo_rd_en, output, 1, meaning a pop strobe; the FIFO advances at the clock edge ending the strobe cycle.
REQ-009 The module SHALL have port cts_n, input, 1, meaning clear-to-send, active-low, already synchronous to clk.
REQ-010 The module SHALL have port tx, output, 1, meaning the serial line, registered, idle high.
REQ-011 The module SHALL have port tx_busy, output, 1, meaning a frame is in progress.
REQ-012 The module SHALL have port tx_done, output, 1, meaning a one-cycle pulse at the end of each completed frame.

Function
REQ-013 The frame format SHALL be 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit lasts exactly BAUD_DIV clocks.
REQ-014 The FSM SHALL have states IDLE, START, DATA, STOP; a baud counter of width $clog2(BAUD_DIV) counts 0..BAUD_DIV-1 and a 3-bit index tracks the data bit.
REQ-015 The launch condition SHALL be !fifo_empty && !cts_n && (state==IDLE || (state==STOP && baud counter==BAUD_DIV-1)).
REQ-016 fifo_rd_en SHALL be combinational and equal to the launch condition, and it SHALL be forced to 0 while rst_n=0.
REQ-017 In any cycle where fifo_rd_en=1, fifo_rd_data SHALL be latched into the shift register, the state SHALL go to START, the baud counter SHALL clear, and tx SHALL go 0 at that same edge.
REQ-018 Latency SHALL be as follows: from IDLE, tx falls at the edge ending the first cycle in which the launch condition is true (0 extra cycles).
REQ-019 When the START counter reaches BAUD_DIV-1, the FSM SHALL enter DATA with tx=bit0; after bit7 completes, it SHALL enter STOP with tx=1.
REQ-020 At the end of STOP, tx_done SHALL pulse high for one cycle; the FSM SHALL then relaunch directly if the launch condition holds (no idle gap, frame period exactly 10*BAUD_DIV), else it SHALL enter IDLE.
REQ-021 tx_busy SHALL be 1 in START, DATA, and STOP, and 0 in IDLE; it SHALL stay 1 across back-to-back frames.
REQ-022 cts_n and fifo_empty SHALL be sampled only at launch; changes mid-frame SHALL NOT affect the current frame.
REQ-023 fifo_rd_en SHALL never assert when fifo_empty=1 and SHALL never assert for two consecutive cycles.
REQ-024 The shift register contents SHALL be unaffected by fifo_rd_data changes after launch.

Reset
REQ-025 While rst_n=0, the outputs SHALL be: tx=1, tx_busy=0, tx_done=0, fifo_rd_en=0, state=IDLE, counters=0.
REQ-026 Reset asserted mid-frame SHALL abort immediately: tx returns to 1 asynchronously, the byte is lost (not re-popped), and no tx_done is produced.
REQ-027 After rst_n deasserts, the first launch SHALL occur no earlier than the first rising edge with rst_n=1.

Verification (CLK_FREQ_HZ=400, BAUD_RATE=100, BAUD_DIV=4)
REQ-028 Single byte: FIFO holds 0xA5, cts_n=0 -> one fifo_rd_en pulse; tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total); tx_done pulses at cycle 40; tx_busy=1 for 40 cycles.
REQ-029 Back-to-back: FIFO holds 0x00 then 0xFF -> fifo_rd_en pulses 40 cycles apart; tx low for 36 cycles, then high for 4 (stop), then low for 4 (start), then high for 36; tx_busy stays 1 for 80 cycles; two tx_done pulses.
REQ-030 Flow control: FIFO non-empty, cts_n=1 -> no fifo_rd_en and tx stays 1; when cts_n drops, tx falls at the edge ending that cycle.
REQ-031 cts_n rises during bit 3 of frame 0x3C with a second byte queued -> the 0x3C frame completes intact, tx_done pulses, the FSM goes to IDLE, and the second byte is not popped.
REQ-032 Reset mid-frame: rst_n low during data bit 4 -> tx=1, tx_busy=0, fifo_rd_en=0 immediately; no tx_done; after release, the next queued byte is sent as a full frame.
REQ-033 Empty FIFO for 100 cycles -> fifo_rd_en=0, tx=1, tx_busy=0 throughout.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter fed from a show-ahead FIFO.
// Pops one byte per frame, honours cts_n at launch and relaunches back-to-back with no idle gap.
module uart_tx #(
    parameter int CLK_FREQ_HZ = 125000000,
    parameter int BAUD_RATE   = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rd_data,
    output logic       fifo_rd_en,
    input  logic       cts_n,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int BAUD_DIV = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CW       = (BAUD_DIV < 2) ? 1 : $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

    generate
        if (BAUD_DIV < 2) begin : g_baud_check
            $error("uart_tx: BAUD_DIV must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_baud;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_tx;
    logic            r_busy;
    logic            r_done;

    logic            w_baud_end;
    logic            w_launch;

    assign w_baud_end = (r_baud == BAUD_LAST);

    // A new frame may start from IDLE, or on the last clock of a stop bit.
    assign w_launch = !fifo_empty && !cts_n &&
                      ((r_state == IDLE) ||
                       ((r_state == STOP) && w_baud_end));

    // The pop strobe is the launch itself; held off while in reset.
    assign fifo_rd_en = w_launch && rst_n;

    assign tx      = r_tx;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

    // Frame sequencer: launches, times each bit and shifts data out LSB first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_baud    <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_launch) begin
                r_state   <= START;
                r_baud    <= '0;
                r_bit_idx <= 3'd0;
                r_shift   <= fifo_rd_data;
                r_tx      <= 1'b0;
                r_busy    <= 1'b1;
                r_done    <= (r_state == STOP);
            end else begin
                unique case (r_state)
                    IDLE: begin
                        r_tx   <= 1'b1;
                        r_busy <= 1'b0;
                    end
                    START: begin
                        if (w_baud_end) begin
                            r_baud    <= '0;
                            r_bit_idx <= 3'd0;
                            r_tx      <= r_shift[0];
                            r_state   <= DATA;
                        end else begin
                            r_baud <= r_baud + 1'b1;
                        end
                    end
                    DATA: begin
                        if (w_baud_end) begin
                            r_baud <= '0;
                            if (r_bit_idx == 3'd7) begin
                                r_tx    <= 1'b1;
                                r_state <= STOP;
                            end else begin
                                r_bit_idx <= r_bit_idx + 3'd1;
                                r_tx      <= r_shift[1];
                                r_shift   <= {1'b0, r_shift[7:1]};
                            end
                        end else begin
                            r_baud <= r_baud + 1'b1;
                        end
                    end
                    STOP: begin
                        if (w_baud_end) begin
                            r_baud  <= '0;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_tx    <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_baud <= r_baud + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
